// File: rtl/fir_p2s_unpacker.sv
// rtl/fir_p2s_unpacker.sv - triplet FIFO that re-serialises my_fir output to one sample per cycle
// Optional LAST output (phase-2 sample marker) enabled by FIR_P2S_LAST_EN.
module fir_p2s_unpacker #(
   parameter int NB    = 8,
   parameter int DEPTH = 4
) (
   input  logic          CLK,
   input  logic          RST_n,
   input  logic [NB-1:0] DIN,
   input  logic [NB-1:0] DIN_2,
   input  logic [NB-1:0] DIN_3,
   input  logic          VIN,
   input  logic          READY,
   output logic [NB-1:0] DOUT,
   output logic          VOUT,
   output logic          FULL,
   output logic          OVF
`ifdef FIR_P2S_LAST_EN
   ,
   output logic          LAST
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

   logic [NB-1:0] r_mem0 [DEPTH];
   logic [NB-1:0] r_mem1 [DEPTH];
   logic [NB-1:0] r_mem2 [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic [1:0]    r_phase;
   logic [NB-1:0] r_dout;
   logic          r_vout;
   logic          r_ovf;
`ifdef FIR_P2S_LAST_EN
   logic          r_last;
`endif

   logic          w_full;
   logic          w_load;
   logic          w_pop;
   logic          w_wr;
   logic [NB-1:0] w_head;

   assign w_full = (r_count == C_DEPTH);
   assign w_load = (!r_vout || READY) && (r_count != '0);
   assign w_pop  = w_load && (r_phase == 2'd2);
   // A pop on the same edge frees a slot, so a write at full is still accepted.
   assign w_wr   = VIN && (!w_full || w_pop);

   always_comb begin
      w_head = r_mem0[r_rptr];
      case (r_phase)
         2'd1:    w_head = r_mem1[r_rptr];
         2'd2:    w_head = r_mem2[r_rptr];
         default: w_head = r_mem0[r_rptr];
      endcase
   end

   always_ff @(posedge CLK) begin
      if (w_wr) begin
         r_mem0[r_wptr] <= DIN;
         r_mem1[r_wptr] <= DIN_2;
         r_mem2[r_wptr] <= DIN_3;
      end
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_phase <= 2'd0;
         r_dout  <= '0;
         r_vout  <= 1'b0;
         r_ovf   <= 1'b0;
`ifdef FIR_P2S_LAST_EN
         r_last  <= 1'b0;
`endif
      end else begin
         if (w_wr)
            r_wptr <= r_wptr + PW'(1);
         if (w_pop)
            r_rptr <= r_rptr + PW'(1);
         r_count <= r_count + CW'(w_wr) - CW'(w_pop);
         if (VIN && !w_wr)
            r_ovf <= 1'b1;
         if (w_load) begin
            r_dout  <= w_head;
            r_vout  <= 1'b1;
            r_phase <= (r_phase == 2'd2) ? 2'd0 : r_phase + 2'd1;
`ifdef FIR_P2S_LAST_EN
            r_last  <= (r_phase == 2'd2);
`endif
         end else if (READY) begin
            r_vout <= 1'b0;
         end
      end
   end

   assign DOUT = r_dout;
   assign VOUT = r_vout;
   assign FULL = w_full;
   assign OVF  = r_ovf;
`ifdef FIR_P2S_LAST_EN
   assign LAST = r_last;
`endif

endmodule

// File: tb/tb_fir_p2s_unpacker.sv
// tb/tb_fir_p2s_unpacker.sv - directed self-checking bench for fir_p2s_unpacker
module tb_fir_p2s_unpacker;

   logic       CLK;
   logic       RST_n;
   logic [7:0] DIN;
   logic [7:0] DIN_2;
   logic [7:0] DIN_3;
   logic       VIN;
   logic       READY;
   logic [7:0] DOUT;
   logic       VOUT;
   logic       FULL;
   logic       OVF;
`ifdef FIR_P2S_LAST_EN
   logic       LAST;
`endif

   int vec_cnt;
   int err_cnt;

   fir_p2s_unpacker #(.NB(8), .DEPTH(4)) dut (
      .CLK   (CLK),
      .RST_n (RST_n),
      .DIN   (DIN),
      .DIN_2 (DIN_2),
      .DIN_3 (DIN_3),
      .VIN   (VIN),
      .READY (READY),
      .DOUT  (DOUT),
      .VOUT  (VOUT),
      .FULL  (FULL),
      .OVF   (OVF)
`ifdef FIR_P2S_LAST_EN
      ,
      .LAST  (LAST)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      VIN   = v;
      DIN   = a;
      DIN_2 = b;
      DIN_3 = c;
   endtask

   task automatic do_reset();
      #2;
      RST_n = 1'b0;
      tick();
      RST_n = 1'b1;
   endtask

   task automatic test_reset();
      RST_n = 1'b0;
      READY = 1'b1;
      drive(1'b0, 8'h00, 8'h00, 8'h00);
      tick();
      tick();
      vec_cnt++;
      if ({VOUT, DOUT, FULL, OVF} !== 11'b0) begin
         $display("FAIL reset_state: got vout=%b dout=%h full=%b ovf=%b expected all 0", VOUT, DOUT, FULL, OVF);
         err_cnt++;
      end
      RST_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      logic [7:0] exp_d [3];
      exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
      READY = 1'b1;
      drive(1'b1, 8'h11, 8'h22, 8'h33);
      tick();
      drive(1'b0, 8'h00, 8'h00, 8'h00);
      vec_cnt++;
      if (VOUT !== 1'b0) begin
         $display("FAIL single_edge_k: vout=%b expected 0", VOUT);
         err_cnt++;
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         vec_cnt++;
         if ({VOUT, DOUT} !== {1'b1, exp_d[i]}) begin
            $display("FAIL single_k%0d: vout=%b dout=%h expected vout=1 dout=%h", i + 1, VOUT, DOUT, exp_d[i]);
            err_cnt++;
         end
`ifdef FIR_P2S_LAST_EN
         vec_cnt++;
         if (LAST !== (i == 2)) begin
            $display("FAIL single_last_k%0d: last=%b expected %b", i + 1, LAST, (i == 2));
            err_cnt++;
         end
`endif
      end
      tick();
      vec_cnt++;
      if ({VOUT, DOUT} !== {1'b0, 8'h33}) begin
         $display("FAIL single_empty: vout=%b dout=%h expected vout=0 dout=33", VOUT, DOUT);
         err_cnt++;
      end
   endtask

   task automatic test_stream();
      logic [7:0] e;
      READY = 1'b1;
      for (int c = 0; c <= 61; c++) begin
         if ((c % 3 == 0) && (c / 3 < 20))
            drive(1'b1, 8'(c), 8'(c + 1), 8'(c + 2));
         else
            drive(1'b0, 8'h00, 8'h00, 8'h00);
         tick();
         e = 8'(c - 1);
         vec_cnt++;
         if (c == 0 || c == 61) begin
            if ({VOUT, FULL, OVF} !== 3'b000) begin
               $display("FAIL stream_idle_c%0d: vout=%b full=%b ovf=%b expected 000", c, VOUT, FULL, OVF);
               err_cnt++;
            end
         end else if ({VOUT, DOUT, FULL, OVF} !== {1'b1, e, 2'b00}) begin
            $display("FAIL stream_c%0d: vout=%b dout=%h full=%b ovf=%b expected vout=1 dout=%h full=0 ovf=0",
                     c, VOUT, DOUT, FULL, OVF, e);
            err_cnt++;
         end
`ifdef FIR_P2S_LAST_EN
         if (c >= 1 && c <= 60) begin
            vec_cnt++;
            if (LAST !== ((c - 1) % 3 == 2)) begin
               $display("FAIL stream_last_c%0d: last=%b expected %b", c, LAST, ((c - 1) % 3 == 2));
               err_cnt++;
            end
         end
`endif
      end
   endtask

   task automatic test_backpressure();
      READY = 1'b1;
      drive(1'b1, 8'h11, 8'h22, 8'h33);
      tick();
      drive(1'b0, 8'h00, 8'h00, 8'h00);
      tick();
      tick();
      vec_cnt++;
      if ({VOUT, DOUT} !== {1'b1, 8'h22}) begin
         $display("FAIL bp_setup: vout=%b dout=%h expected vout=1 dout=22", VOUT, DOUT);
         err_cnt++;
      end
      READY = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         vec_cnt++;
         if ({VOUT, DOUT} !== {1'b1, 8'h22}) begin
            $display("FAIL bp_hold_%0d: vout=%b dout=%h expected vout=1 dout=22", i, VOUT, DOUT);
            err_cnt++;
         end
      end
      READY = 1'b1;
      tick();
      vec_cnt++;
      if ({VOUT, DOUT} !== {1'b1, 8'h33}) begin
         $display("FAIL bp_resume: vout=%b dout=%h expected vout=1 dout=33", VOUT, DOUT);
         err_cnt++;
      end
      tick();
   endtask

   task automatic test_overflow();
      logic [7:0] e;
      logic       exp_full;
      logic       exp_ovf;
      READY = 1'b0;
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 8'(8'h40 + i * 4), 8'(8'h41 + i * 4), 8'(8'h42 + i * 4));
         tick();
         exp_full = (i >= 3);
         exp_ovf  = (i >= 4);
         vec_cnt++;
         if ({FULL, OVF} !== {exp_full, exp_ovf}) begin
            $display("FAIL ovf_fill_%0d: full=%b ovf=%b expected full=%b ovf=%b", i, FULL, OVF, exp_full, exp_ovf);
            err_cnt++;
         end
      end
      drive(1'b0, 8'h00, 8'h00, 8'h00);
      vec_cnt++;
      if ({VOUT, DOUT} !== {1'b1, 8'h40}) begin
         $display("FAIL ovf_head: vout=%b dout=%h expected vout=1 dout=40", VOUT, DOUT);
         err_cnt++;
      end
      READY = 1'b1;
      for (int j = 1; j < 12; j++) begin
         tick();
         e = 8'(8'h40 + (j / 3) * 4 + (j % 3));
         vec_cnt++;
         if ({VOUT, DOUT, OVF} !== {1'b1, e, 1'b1}) begin
            $display("FAIL ovf_drain_%0d: vout=%b dout=%h ovf=%b expected vout=1 dout=%h ovf=1", j, VOUT, DOUT, OVF, e);
            err_cnt++;
         end
      end
      tick();
      vec_cnt++;
      if ({VOUT, FULL, OVF} !== 3'b001) begin
         $display("FAIL ovf_end: vout=%b full=%b ovf=%b expected vout=0 full=0 ovf=1", VOUT, FULL, OVF);
         err_cnt++;
      end
   endtask

   task automatic test_full_pop();
      logic [7:0] e;
      int         t;
      do_reset();
      READY = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 8'(8'h60 + i * 4), 8'(8'h61 + i * 4), 8'(8'h62 + i * 4));
         tick();
      end
      drive(1'b0, 8'h00, 8'h00, 8'h00);
      vec_cnt++;
      if ({FULL, VOUT, DOUT} !== {2'b11, 8'h60}) begin
         $display("FAIL fp_full: full=%b vout=%b dout=%h expected full=1 vout=1 dout=60", FULL, VOUT, DOUT);
         err_cnt++;
      end
      READY = 1'b1;
      tick();
      drive(1'b1, 8'h70, 8'h71, 8'h72);
      tick();
      drive(1'b0, 8'h00, 8'h00, 8'h00);
      vec_cnt++;
      if ({DOUT, FULL, OVF} !== {8'h62, 2'b10}) begin
         $display("FAIL fp_accept: dout=%h full=%b ovf=%b expected dout=62 full=1 ovf=0", DOUT, FULL, OVF);
         err_cnt++;
      end
      for (int j = 0; j < 12; j++) begin
         tick();
         t = j / 3 + 1;
         e = (t < 4) ? 8'(8'h60 + t * 4 + j % 3) : 8'(8'h70 + j % 3);
         vec_cnt++;
         if ({VOUT, DOUT, OVF} !== {1'b1, e, 1'b0}) begin
            $display("FAIL fp_drain_%0d: vout=%b dout=%h ovf=%b expected vout=1 dout=%h ovf=0", j, VOUT, DOUT, OVF, e);
            err_cnt++;
         end
      end
      tick();
      vec_cnt++;
      if (VOUT !== 1'b0) begin
         $display("FAIL fp_end: vout=%b expected 0", VOUT);
         err_cnt++;
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] exp_d [3];
      exp_d[0] = 8'h81; exp_d[1] = 8'h82; exp_d[2] = 8'h83;
      READY = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 8'(8'hA0 + i * 4), 8'(8'hA1 + i * 4), 8'(8'hA2 + i * 4));
         tick();
      end
      drive(1'b0, 8'h00, 8'h00, 8'h00);
      vec_cnt++;
      if ({VOUT, DOUT} !== {1'b1, 8'hA0}) begin
         $display("FAIL rm_setup: vout=%b dout=%h expected vout=1 dout=a0", VOUT, DOUT);
         err_cnt++;
      end
      #2;
      RST_n = 1'b0;
      #1;
      vec_cnt++;
      if ({VOUT, DOUT, FULL, OVF} !== 11'b0) begin
         $display("FAIL rm_async: vout=%b dout=%h full=%b ovf=%b expected all 0", VOUT, DOUT, FULL, OVF);
         err_cnt++;
      end
      tick();
      RST_n = 1'b1;
      READY = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         vec_cnt++;
         if (VOUT !== 1'b0) begin
            $display("FAIL rm_quiet_%0d: vout=%b expected 0", i, VOUT);
            err_cnt++;
         end
      end
      drive(1'b1, 8'h81, 8'h82, 8'h83);
      tick();
      drive(1'b0, 8'h00, 8'h00, 8'h00);
      for (int i = 0; i < 3; i++) begin
         tick();
         vec_cnt++;
         if ({VOUT, DOUT} !== {1'b1, exp_d[i]}) begin
            $display("FAIL rm_new_%0d: vout=%b dout=%h expected vout=1 dout=%h", i, VOUT, DOUT, exp_d[i]);
            err_cnt++;
         end
      end
   endtask

   initial begin
      vec_cnt = 0;
      err_cnt = 0;
      test_reset();
      test_single();
      test_stream();
      test_backpressure();
      test_overflow();
      test_full_pop();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
